// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: default widths, FSM encoding,
// wait-counter sizing and a configuration sanity helper.
package dmem_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic bit latency_ok(input int lat);
    return (lat >= 1) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage for the responder; read data is registered and only
// refreshed on a read strobe, so it holds steady while a response is pending.
module dmem_array #(
  parameter int DEPTH  = 65536,
  parameter int DATA_W = 16,
  parameter int AW     = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Target end of the load/store port: one outstanding request, fixed wait of LATENCY
// cycles, then a held response until the initiator consumes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 65536,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_write,
  output logic              resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable and never flags an error.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..%0d", LATENCY_MAX);
  end
  if ((DEPTH < 1) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be in 1..2**ADDR_W");
  end

  logic [1:0]        r_state;
  cnt_t              r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd_sel;
  logic              r_err;

  logic              w_accept;
  logic              w_access;
  logic              w_in_range;
  logic              w_arr_we;
  logic              w_arr_re;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_in_range = {1'b0, r_addr} < DEPTH_L;
  // The access edge is suppressed while reset is asserted so an aborted store never lands.
  assign w_access   = (r_state == ST_WAIT) && (r_cnt == '0) && reset;
  assign w_arr_we   = w_access && w_in_range && r_write;
  assign w_arr_re   = w_access && w_in_range && !r_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_rd_sel <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_write <= req_write;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state  <= ST_RESP;
            r_err    <= !w_in_range;
            r_rd_sel <= w_in_range && !r_write;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  dmem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  (r_addr[AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_arr_rdata)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rd_sel ? w_arr_rdata : '0;
  assign resp_write = r_write;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder built with LATENCY=3 and DEPTH=256.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_write;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rd;
  logic        rw;
  logic        re;

  dmem_responder #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .DEPTH   (256),
    .LATENCY (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_write (resp_write),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request and return at the negedge just after the accept edge,
  // with the request inputs already scrambled.
  task automatic send_req(input logic wr, input logic [15:0] a, input logic [15:0] d);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = ~wr;
    req_addr  = ~a;
    req_wdata = ~d;
  endtask

  task automatic wait_resp(output logic [15:0] o_rd, output logic o_rw, output logic o_re);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("resp_valid_wait", 32'(n < 20), 32'd1);
    o_rd = resp_rdata;
    o_rw = resp_write;
    o_re = resp_err;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic xact(input logic wr, input logic [15:0] a, input logic [15:0] d,
                      output logic [15:0] o_rd, output logic o_rw, output logic o_re);
    send_req(wr, a, d);
    wait_resp(o_rd, o_rw, o_re);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    // 1: reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'h0);
    chk("rst_resp_write", 32'(resp_write), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // 2: store then load
    xact(1'b1, 16'h0001, 16'h1234, rd, rw, re);
    chk("st_rdata", 32'(rd), 32'h0);
    chk("st_write", 32'(rw), 32'd1);
    chk("st_err", 32'(re), 32'd0);
    xact(1'b0, 16'h0001, 16'h0000, rd, rw, re);
    chk("ld_rdata", 32'(rd), 32'h1234);
    chk("ld_write", 32'(rw), 32'd0);
    chk("ld_err", 32'(re), 32'd0);

    // 3: latency, k counts negedges after the accept edge
    send_req(1'b0, 16'h0001, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("lat_valid_k%0d", k), 32'(resp_valid), 32'(k == 4));
      chk($sformatf("lat_ready_k%0d", k), 32'(req_ready), 32'd0);
      if (k < 4) @(negedge clk);
    end
    chk("lat_rdata", 32'(resp_rdata), 32'h1234);
    consume();
    chk("lat_back_idle", 32'(req_ready), 32'd1);

    // 4: backpressure
    xact(1'b1, 16'h0005, 16'hBEEF, rd, rw, re);
    send_req(1'b0, 16'h0005, 16'h0000);
    wait_resp(rd, rw, re);
    chk("bp_first_rdata", 32'(rd), 32'hBEEF);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 16'h0005;
    req_wdata = 16'h1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_c%0d", c), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), 32'(resp_rdata), 32'hBEEF);
      chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    consume();
    xact(1'b0, 16'h0005, 16'h0000, rd, rw, re);
    chk("bp_not_overwritten", 32'(rd), 32'hBEEF);

    // 5: range checks at DEPTH=256
    xact(1'b1, 16'h00FF, 16'h0F0F, rd, rw, re);
    chk("rng_st_ff_err", 32'(re), 32'd0);
    xact(1'b1, 16'h0100, 16'hAAAA, rd, rw, re);
    chk("rng_st_100_err", 32'(re), 32'd1);
    chk("rng_st_100_write", 32'(rw), 32'd1);
    chk("rng_st_100_rdata", 32'(rd), 32'h0);
    xact(1'b0, 16'h00FF, 16'h0000, rd, rw, re);
    chk("rng_ld_ff_rdata", 32'(rd), 32'h0F0F);
    chk("rng_ld_ff_err", 32'(re), 32'd0);
    xact(1'b0, 16'h0100, 16'h0000, rd, rw, re);
    chk("rng_ld_100_err", 32'(re), 32'd1);
    chk("rng_ld_100_rdata", 32'(rd), 32'h0);
    xact(1'b0, 16'hFFFF, 16'h0000, rd, rw, re);
    chk("rng_ld_ffff_err", 32'(re), 32'd1);
    xact(1'b0, 16'h0000, 16'h0000, rd, rw, re);
    chk("rng_ld_0_err", 32'(re), 32'd0);

    // 6: reset on the would-be access edge aborts the store
    xact(1'b1, 16'h0002, 16'h0000, rd, rw, re);
    send_req(1'b1, 16'h0002, 16'h5555);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_late_resp", 32'(resp_valid), 32'd0);
    xact(1'b0, 16'h0002, 16'h0000, rd, rw, re);
    chk("abort_mem_kept", 32'(rd), 32'h0000);

    // reset while a response is pending drops it
    send_req(1'b0, 16'h0001, 16'h0000);
    wait_resp(rd, rw, re);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("drop_resp_valid", 32'(resp_valid), 32'd0);
    chk("drop_resp_rdata", 32'(resp_rdata), 32'h0);
    chk("drop_req_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
